// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS bus master and its lane-steering logic.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } bm_state_t;

    // An illegal size encoding is reported as misaligned so one check covers both errors.
    function automatic logic is_aligned(input logic [1:0] addr, input logic [1:0] size);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr[0];
            SIZE_WORD: ok = (addr == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Combinational byte-lane steering for stores and alignment/extension for loads.
module bus_lane_align
    import mips_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    input  logic        is_unsigned,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = 8'(readdata >> {addr_lo, 3'b000});
    assign half_lane = addr_lo[1] ? readdata[31:16] : readdata[15:0];

    always_comb begin
        byteenable = 4'b0000;
        writedata  = 32'h0;
        load_data  = 32'h0;
        case (size)
            SIZE_BYTE: begin
                byteenable = 4'b0001 << addr_lo;
                writedata  = {4{wdata[7:0]}};
                load_data  = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            end
            SIZE_HALF: begin
                byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{wdata[15:0]}};
                load_data  = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            end
            SIZE_WORD: begin
                byteenable = 4'b1111;
                writedata  = wdata;
                load_data  = readdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_bus_master.sv
// CPU-side bus initiator: one load/store at a time, lane steering, stall wait and watchdog.
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    bm_state_t        state_q, state_d;
    logic             read_q, read_d, write_q, write_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      address_q, address_d, writedata_q, writedata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       size_q, size_d, alo_q, alo_d;
    logic             uns_q, uns_d;

    logic [1:0]       ln_size, ln_alo;
    logic             ln_uns;
    logic [3:0]       ln_be;
    logic [31:0]      ln_wdata, ln_load;

    // One lane unit: fed from the core while idle, from the latched request afterwards.
    assign ln_size = (state_q == IDLE) ? cpu_size     : size_q;
    assign ln_alo  = (state_q == IDLE) ? cpu_addr[1:0] : alo_q;
    assign ln_uns  = (state_q == IDLE) ? cpu_unsigned : uns_q;

    bus_lane_align u_lane (
        .size        (ln_size),
        .addr_lo     (ln_alo),
        .wdata       (cpu_wdata),
        .readdata    (readdata),
        .is_unsigned (ln_uns),
        .byteenable  (ln_be),
        .writedata   (ln_wdata),
        .load_data   (ln_load)
    );

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        be_d        = be_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        size_d      = size_q;
        alo_d       = alo_q;
        uns_d       = uns_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (!is_aligned(cpu_addr[1:0], cpu_size)) begin
                        err_d = 1'b1;
                    end else begin
                        size_d      = cpu_size;
                        alo_d       = cpu_addr[1:0];
                        uns_d       = cpu_unsigned;
                        address_d   = {cpu_addr[31:2], 2'b00};
                        be_d        = ln_be;
                        writedata_d = ln_wdata;
                        read_d      = ~cpu_we;
                        write_d     = cpu_we;
                        cnt_d       = '0;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (read_q) rdata_d = ln_load;
                    done_d  = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            be_q        <= 4'b0000;
            address_q   <= 32'h0;
            writedata_q <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            alo_q       <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            be_q        <= be_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            alo_q       <= alo_d;
            uns_q       <= uns_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_done   = done_q;
    assign cpu_err    = err_q;
    assign cpu_busy   = (state_q != IDLE);
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = be_q;
    assign writedata  = writedata_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Directed bench for mips_bus_master against a 16-byte bus memory with programmable stalls.
module tb_mips_bus_master;

    logic        clk, reset_n;
    logic        cpu_req, req_t, cpu_we, cpu_unsigned;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata, address, writedata, readdata;
    logic        cpu_done, cpu_err, cpu_busy, read, write, waitrequest;
    logic [3:0]  byteenable;

    logic [31:0] t_rdata, t_address, t_writedata;
    logic        t_done, t_err, t_busy, t_read, t_write;
    logic [3:0]  t_be;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:15];
    int         stall_w;
    int         ws_cnt;
    logic [3:0] mbase;

    mips_bus_master dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .cpu_err(cpu_err), .cpu_busy(cpu_busy), .address(address), .read(read),
        .write(write), .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    // Watchdog instance: responder never releases the stall.
    mips_bus_master #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset_n(reset_n), .cpu_req(req_t), .cpu_we(cpu_we),
        .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(t_rdata), .cpu_done(t_done),
        .cpu_err(t_err), .cpu_busy(t_busy), .address(t_address), .read(t_read),
        .write(t_write), .byteenable(t_be), .writedata(t_writedata),
        .waitrequest(1'b1), .readdata(32'h0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mbase       = {address[3:2], 2'b00};
    assign readdata    = {mem[mbase + 4'd3], mem[mbase + 4'd2], mem[mbase + 4'd1], mem[mbase]};
    assign waitrequest = (read || write) && (ws_cnt < stall_w);

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[4] <= 8'h66; mem[5] <= 8'h86; mem[6] <= 8'h02; mem[7] <= 8'h24;
            ws_cnt <= 0;
        end else begin
            if (!(read || write)) ws_cnt <= 0;
            else if (waitrequest) ws_cnt <= ws_cnt + 1;
            if (write && !waitrequest)
                for (int i = 0; i < 4; i++)
                    if (byteenable[i]) mem[int'(mbase) + i] <= writedata[8*i +: 8];
        end
    end

    // Issues one access and observes it until cpu_done (bounded); returns what was seen.
    task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                              output int done_cyc, output logic [31:0] rdata,
                              output logic [3:0] be_o, output logic [31:0] wd_o,
                              output logic [31:0] addr_o, output logic rd_o,
                              output logic wr_o, output logic stable);
        stall_w = stall;
        cpu_we = we; cpu_size = size; cpu_unsigned = uns; cpu_addr = addr; cpu_wdata = wdata;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        be_o = byteenable; wd_o = writedata; addr_o = address; rd_o = read; wr_o = write;
        stable = 1'b1; done_cyc = -1; rdata = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (cpu_done === 1'b1) begin
                done_cyc = c; rdata = cpu_rdata;
                if (read !== 1'b0 || write !== 1'b0) stable = 1'b0;
                break;
            end
            if (read !== rd_o || write !== wr_o || address !== addr_o ||
                byteenable !== be_o || writedata !== wd_o) stable = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({read, write, cpu_done, cpu_err, cpu_busy} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctrl got %b want 00000", {read, write, cpu_done, cpu_err, cpu_busy}); end
        vectors++; if ({address, writedata, cpu_rdata, byteenable} !== 100'h0) begin
            miscompares++; $display("FAIL reset_data got %h %h %h %b want zeros", address, writedata, cpu_rdata, byteenable); end
        vectors++; if ({t_read, t_write, t_err, t_busy} !== 4'b0) begin
            miscompares++; $display("FAIL reset_wd_inst got %b want 0000", {t_read, t_write, t_err, t_busy}); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        int dc; logic [31:0] rd, wd, ad; logic [3:0] be; logic r, w, st;
        run_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1, dc, rd, be, wd, ad, r, w, st);
        vectors++; if (dc !== 2) begin miscompares++; $display("FAIL lw_latency got %0d want 2", dc); end
        vectors++; if (rd !== 32'h24028666) begin miscompares++; $display("FAIL lw_data got %h want 24028666", rd); end
        vectors++; if ({r, w, be, ad} !== {1'b1, 1'b0, 4'b1111, 32'h4}) begin
            miscompares++; $display("FAIL lw_bus got r=%b w=%b be=%b a=%h want 1 0 1111 00000004", r, w, be, ad); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL lw_stable got %b want 1", st); end
        run_access(1'b0, 2'b10, 1'b1, 32'h4, 32'h0, 1, dc, rd, be, wd, ad, r, w, st);
        vectors++; if (rd !== 32'h24028666) begin miscompares++; $display("FAIL lw_unsigned_ignored got %h want 24028666", rd); end
    endtask

    task automatic test_load_subword();
        logic [31:0] addrs [7] = '{32'h5, 32'h5, 32'h6, 32'h4, 32'h4, 32'h7, 32'h4};
        logic [1:0]  sizes [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic        unss  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exps  [7] = '{32'hFFFFFF86, 32'h00000086, 32'h00002402, 32'h00008666,
                                   32'hFFFF8666, 32'h00000024, 32'h00000066};
        logic [3:0]  bes   [7] = '{4'b0010, 4'b0010, 4'b1100, 4'b0011, 4'b0011, 4'b1000, 4'b0001};
        int dc; logic [31:0] rd, wd, ad; logic [3:0] be; logic r, w, st;
        for (int i = 0; i < 7; i++) begin
            run_access(1'b0, sizes[i], unss[i], addrs[i], 32'h0, 1, dc, rd, be, wd, ad, r, w, st);
            vectors++; if (rd !== exps[i] || dc !== 2) begin
                miscompares++; $display("FAIL subload_%0d data got %h (cyc %0d) want %h (cyc 2)", i, rd, dc, exps[i]); end
            vectors++; if (be !== bes[i] || ad !== 32'h4) begin
                miscompares++; $display("FAIL subload_%0d lanes got be=%b a=%h want be=%b a=00000004", i, be, ad, bes[i]); end
        end
    endtask

    task automatic test_store();
        int dc; logic [31:0] rd, wd, ad; logic [3:0] be; logic r, w, st;
        run_access(1'b1, 2'b00, 1'b0, 32'h2, 32'h000000AB, 1, dc, rd, be, wd, ad, r, w, st);
        vectors++; if ({r, w, be, wd, ad} !== {1'b0, 1'b1, 4'b0100, 32'hABABABAB, 32'h0}) begin
            miscompares++; $display("FAIL sb_bus got r=%b w=%b be=%b wd=%h a=%h want 0 1 0100 abababab 0", r, w, be, wd, ad); end
        vectors++; if (dc !== 2) begin miscompares++; $display("FAIL sb_latency got %0d want 2", dc); end
        run_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1, dc, rd, be, wd, ad, r, w, st);
        vectors++; if (rd !== 32'h00AB0000) begin miscompares++; $display("FAIL sb_readback got %h want 00ab0000", rd); end
        run_access(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234BEEF, 1, dc, rd, be, wd, ad, r, w, st);
        vectors++; if ({be, wd, ad} !== {4'b1100, 32'hBEEFBEEF, 32'h8}) begin
            miscompares++; $display("FAIL sh_bus got be=%b wd=%h a=%h want 1100 beefbeef 00000008", be, wd, ad); end
        run_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1, dc, rd, be, wd, ad, r, w, st);
        vectors++; if (rd !== 32'hBEEF0000) begin miscompares++; $display("FAIL sh_readback got %h want beef0000", rd); end
        run_access(1'b1, 2'b10, 1'b1, 32'hC, 32'hCAFEF00D, 1, dc, rd, be, wd, ad, r, w, st);
        run_access(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 1, dc, rd, be, wd, ad, r, w, st);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL sw_readback got %h want cafef00d", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h5, 32'h0, 32'h6};
        logic [1:0]  sizes [3] = '{2'b01, 2'b11, 2'b10};
        logic        wes   [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            cpu_we = wes[i]; cpu_size = sizes[i]; cpu_addr = addrs[i]; cpu_wdata = 32'h55; cpu_req = 1'b1;
            @(posedge clk); #1;
            cpu_req = 1'b0;
            vectors++; if ({cpu_err, read, write, cpu_busy} !== 4'b1000) begin
                miscompares++; $display("FAIL bad_req_%0d pulse got %b want 1000", i, {cpu_err, read, write, cpu_busy}); end
            @(posedge clk); #1;
            vectors++; if ({cpu_err, cpu_done, read, write} !== 4'b0000) begin
                miscompares++; $display("FAIL bad_req_%0d after got %b want 0000", i, {cpu_err, cpu_done, read, write}); end
        end
    endtask

    task automatic test_stall();
        int dc; logic [31:0] rd, wd, ad; logic [3:0] be; logic r, w, st;
        run_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 6, dc, rd, be, wd, ad, r, w, st);
        vectors++; if (dc !== 7) begin miscompares++; $display("FAIL stall_latency got %0d want 7", dc); end
        vectors++; if (st !== 1'b1 || rd !== 32'h24028666) begin
            miscompares++; $display("FAIL stall_hold got stable=%b data=%h want 1 24028666", st, rd); end
    endtask

    task automatic test_timeout();
        logic [4:0] seen [6];
        cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h4; req_t = 1'b1;
        @(posedge clk); #1;
        req_t = 1'b0;
        seen[0] = {t_read, t_write, t_err, t_done, t_busy};
        for (int c = 1; c < 6; c++) begin
            @(posedge clk); #1;
            seen[c] = {t_read, t_write, t_err, t_done, t_busy};
        end
        vectors++; if (seen[0] !== 5'b10001 || seen[3] !== 5'b10001) begin
            miscompares++; $display("FAIL timeout_waiting got %b/%b want 10001/10001", seen[0], seen[3]); end
        vectors++; if (seen[4] !== 5'b00100) begin miscompares++; $display("FAIL timeout_abort got %b want 00100", seen[4]); end
        vectors++; if (seen[5] !== 5'b00000) begin miscompares++; $display("FAIL timeout_after got %b want 00000", seen[5]); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] rd_seq, done_seq;
        stall_w = 1;
        cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0; cpu_addr = 32'h4; cpu_req = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            rd_seq[c] = read; done_seq[c] = cpu_done;
            if (c == 4) cpu_req = 1'b0;
        end
        vectors++; if (rd_seq !== 7'b0110011) begin miscompares++; $display("FAIL b2b_read got %b want 0110011", rd_seq); end
        vectors++; if (done_seq !== 7'b1000100) begin miscompares++; $display("FAIL b2b_done got %b want 1000100", done_seq); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [1:0] pulses;
        stall_w = 10;
        cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h4; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        vectors++; if (read !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got read=%b want 1", read); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        vectors++; if ({read, write, cpu_done, cpu_err, cpu_busy, byteenable, address, writedata, cpu_rdata} !== 105'h0) begin
            miscompares++; $display("FAIL midrst_zero got r=%b w=%b busy=%b be=%b a=%h want all zero", read, write, cpu_busy, byteenable, address); end
        reset_n = 1'b1;
        pulses = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            pulses = pulses | {cpu_done, cpu_err};
        end
        vectors++; if (pulses !== 2'b00) begin miscompares++; $display("FAIL midrst_nopulse got %b want 00", pulses); end
    endtask

    initial begin
        reset_n = 1'b0; cpu_req = 1'b0; req_t = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00;
        cpu_unsigned = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; stall_w = 1;
        test_reset();
        test_load_word();
        test_load_subword();
        test_store();
        test_misaligned();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
